// File: rtl/aes_inv_round_unit_pkg.sv
// aes_inv_pkg: shared types and GF(2^8) helpers for the AES-128
// inverse round unit.
//   op_e    - transaction opcode (INIT / MID / FINAL, 3 aliases FINAL)
//   state_e - round-unit FSM states
//   xtime / gf_mul09/0b/0d/0e - constant multipliers built from xtime chains
//   byte_msb - (row,col) -> MSB bit position of that byte in a 128-bit state
package aes_inv_pkg;

  typedef enum logic [1:0] {
    OP_INIT  = 2'd0,
    OP_MID   = 2'd1,
    OP_FINAL = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MIX  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul09(input logic [7:0] a);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(a)));
    return x8 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul0b(input logic [7:0] a);
    logic [7:0] x2, x8;
    x2 = xtime(a);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul0d(input logic [7:0] a);
    logic [7:0] x4, x8;
    x4 = xtime(xtime(a));
    x8 = xtime(x4);
    return x8 ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul0e(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // byte i = 4*col + row sits at [127-8i -: 8]
  function automatic int byte_msb(input int row, input int col);
    return 127 - 8 * (4 * col + row);
  endfunction

endpackage

// File: rtl/aes_inv_round_unit_if.sv
// aes_inv_round_unit_if: valid/ready request and response channels of the
// inverse round unit.
//   in_valid/in_ready/in_state/in_key/in_op - request (state, round key, op)
//   out_valid/out_ready/out_state           - response state
//   master: producer of requests / consumer of results (the round loop)
//   slave : the round unit
interface aes_inv_round_unit_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_key;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid, in_state, in_key, in_op, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_key, in_op, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/aes_inv_round_unit_inv_mix_column.sv
// inv_mix_column: combinational InvMixColumn on one 32-bit column.
//   col_in  - bytes a0..a3, a0 (row 0) in [31:24]
//   col_out - bytes b0..b3, b_r = 0e.a_r ^ 0b.a_r+1 ^ 0d.a_r+2 ^ 09.a_r+3
module inv_mix_column
  import aes_inv_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);
  logic [3:0][7:0] a, b;

  // packed [3] is the MSB byte, so row r lives at index 3-r
  assign a = col_in;

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign b[3-r] = gf_mul0e(a[3-r])
                  ^ gf_mul0b(a[3-((r+1)%4)])
                  ^ gf_mul0d(a[3-((r+2)%4)])
                  ^ gf_mul09(a[3-((r+3)%4)]);
  end

  assign col_out = b;
endmodule

// File: rtl/aes_inv_round_unit.sv
// aes_inv_round_unit: AES-128 inverse-cipher round datapath.
// Applies AddRoundKey, then (MID only) a column-serial InvMixColumns over
// four cycles, then InvShiftRows (INIT/MID). The result is held until the
// downstream InvSubBytes stage takes it; input and output handshakes never
// overlap.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - slave side of aes_inv_round_unit_if
module aes_inv_round_unit
  import aes_inv_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  aes_inv_round_unit_if.slave bus
);
  state_e       st;
  logic [1:0]   col;
  logic [127:0] st_reg;
  logic         in_ready_q;
  logic         out_valid_q;

  logic [127:0] ark, mixed, isr_src, isr_out;
  logic [31:0]  col_in, col_out;

  assign ark = bus.in_state ^ bus.in_key;

  // single shared column mixer, steered by the column counter
  always_comb begin
    mixed  = st_reg;
    col_in = st_reg[127:96];
    case (col)
      2'd0: begin col_in = st_reg[127:96]; mixed[127:96] = col_out; end
      2'd1: begin col_in = st_reg[95:64];  mixed[95:64]  = col_out; end
      2'd2: begin col_in = st_reg[63:32];  mixed[63:32]  = col_out; end
      default: begin col_in = st_reg[31:0]; mixed[31:0] = col_out; end
    endcase
  end

  inv_mix_column u_imc (
    .col_in  (col_in),
    .col_out (col_out)
  );

  // ISR feeds from the last mixed column in MIX, from the ARK result in IDLE
  assign isr_src = (st == ST_MIX) ? mixed : ark;

  for (genvar r = 0; r < 4; r++) begin : g_isr_r
    for (genvar c = 0; c < 4; c++) begin : g_isr_c
      localparam int DST = byte_msb(r, c);
      localparam int SRC = byte_msb(r, (c + 4 - r) % 4);
      assign isr_out[DST -: 8] = isr_src[SRC -: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= ST_IDLE;
      col         <= 2'd0;
      st_reg      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            case (op_e'(bus.in_op))
              OP_INIT: begin
                st_reg      <= isr_out;
                st          <= ST_DONE;
                out_valid_q <= 1'b1;
              end
              OP_MID: begin
                st_reg <= ark;
                col    <= 2'd0;
                st     <= ST_MIX;
              end
              default: begin  // FINAL and reserved
                st_reg      <= ark;
                st          <= ST_DONE;
                out_valid_q <= 1'b1;
              end
            endcase
          end
        end
        ST_MIX: begin
          if (col == 2'd3) begin
            st_reg      <= isr_out;
            col         <= 2'd0;
            st          <= ST_DONE;
            out_valid_q <= 1'b1;
          end else begin
            st_reg <= mixed;
            col    <= col + 2'd1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            st          <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = st_reg;
endmodule

// File: tb/tb_aes_inv_round_unit.sv
// tb_aes_inv_round_unit: directed self-checking bench for aes_inv_round_unit.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_aes_inv_round_unit;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  aes_inv_round_unit_if bus ();

  aes_inv_round_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] INIT_IN  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] INIT_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] INIT_EXP = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
  localparam logic [127:0] MID_IN   = 128'h8e4da1bc010101010101010101010101;
  localparam logic [127:0] MID_EXP  = 128'hdb010101011301010101530101010145;
  localparam logic [127:0] FIN_IN   = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] FIN_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIN_EXP  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] A5       = {16{8'ha5}};
  localparam logic [127:0] K5A      = {16{8'h5a}};
  localparam logic [127:0] ONES     = {16{8'hff}};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [127:0] s, input logic [127:0] k);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_state = s;
    bus.in_key   = k;
  endtask

  task automatic test_reset();
    #3;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    n_chk++; if (bus.out_state !== 128'h0) begin n_fail++; $display("FAIL reset_out_state got %h exp 0", bus.out_state); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_init();
    drive(2'd0, INIT_IN, INIT_KEY);
    step();
    bus.in_valid = 1'b0;
    n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL init_valid got %b exp 1", bus.out_valid); end
    n_chk++; if (bus.out_state !== INIT_EXP) begin n_fail++; $display("FAIL init_state got %h exp %h", bus.out_state, INIT_EXP); end
    n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL init_in_ready got %b exp 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL init_drain_valid got %b exp 0", bus.out_valid); end
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL init_drain_ready got %b exp 1", bus.in_ready); end
  endtask

  // MID result with 5-edge latency (accept edge included); leaves result pending
  task automatic test_mid(input string tag);
    drive(2'd1, MID_IN, 128'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      bus.in_valid = 1'b0;
      n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early_valid edge %0d got %b exp 0", tag, i, bus.out_valid); end
      n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL %s_mix_ready edge %0d got %b exp 0", tag, i, bus.in_ready); end
    end
    step();
    n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid got %b exp 1", tag, bus.out_valid); end
    n_chk++; if (bus.out_state !== MID_EXP) begin n_fail++; $display("FAIL %s_state got %h exp %h", tag, bus.out_state, MID_EXP); end
    n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL %s_done_ready got %b exp 0", tag, bus.in_ready); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 10; i++) begin
      if (i[0]) drive(2'd2, A5, K5A);
      else bus.in_valid = 1'b0;
      step();
      n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc %0d got %b exp 1", i, bus.out_valid); end
      n_chk++; if (bus.out_state !== MID_EXP) begin n_fail++; $display("FAIL bp_state cyc %0d got %h exp %h", i, bus.out_state, MID_EXP); end
      n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cyc %0d got %b exp 0", i, bus.in_ready); end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b exp 0", bus.out_valid); end
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_final(input logic [1:0] op, input logic [127:0] s,
                            input logic [127:0] k, input logic [127:0] exp, input string tag);
    drive(op, s, k);
    step();
    bus.in_valid = 1'b0;
    n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid got %b exp 1", tag, bus.out_valid); end
    n_chk++; if (bus.out_state !== exp) begin n_fail++; $display("FAIL %s_state got %h exp %h", tag, bus.out_state, exp); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_drain_ready got %b exp 1", tag, bus.in_ready); end
  endtask

  task automatic test_reset_mid();
    drive(2'd1, MID_IN, 128'h0);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    n_chk++; if (dut.col !== 2'd2) begin n_fail++; $display("FAIL rmid_col_pre got %0d exp 2", dut.col); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", bus.out_valid); end
    n_chk++; if (bus.out_state !== 128'h0) begin n_fail++; $display("FAIL rmid_state got %h exp 0", bus.out_state); end
    n_chk++; if (dut.col !== 2'd0) begin n_fail++; $display("FAIL rmid_col got %0d exp 0", dut.col); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready got %b exp 1", bus.in_ready); end
    test_mid("rmid_again");
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  // out_ready tied high: next op is accepted two edges after the previous one
  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    drive(2'd0, INIT_IN, INIT_KEY);
    step();
    n_chk++; if (bus.out_state !== INIT_EXP) begin n_fail++; $display("FAIL b2b_first got %h exp %h", bus.out_state, INIT_EXP); end
    drive(2'd2, FIN_IN, FIN_KEY);
    step();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_valid got %b exp 0", bus.out_valid); end
    step();
    bus.in_valid = 1'b0;
    n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid got %b exp 1", bus.out_valid); end
    n_chk++; if (bus.out_state !== FIN_EXP) begin n_fail++; $display("FAIL b2b_second got %h exp %h", bus.out_state, FIN_EXP); end
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.in_key    = '0;
    bus.in_op     = 2'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_init();
    test_mid("mid");
    test_backpressure();
    test_final(2'd2, FIN_IN, FIN_KEY, FIN_EXP, "final");
    test_final(2'd3, A5, K5A, ONES, "rsvd");
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
